// File: rtl/fetch_queue.sv
// Instruction-fetch buffer: gates the PC, tags each synchronous-ROM word with the
// PC that fetched it, and queues {pc, instruction} pairs for decode.
module fetch_queue #(
  parameter int ADDR_W = 6,
  parameter int INST_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         resetIn,
  input  logic [ADDR_W-1:0]            pcAddr,
  input  logic [INST_W-1:0]            romData,
  input  logic                         flush,
  output logic                         pcEnable,
  output logic                         instValid,
  input  logic                         instReady,
  output logic [INST_W-1:0]            instOut,
  output logic [ADDR_W-1:0]            instPc,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W+1)'(DEPTH);

  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic              inflight_q, inflight_d;
  logic [ADDR_W-1:0] tag_pc_q, tag_pc_d;
  logic [INST_W-1:0] inst_mem_q [DEPTH];
  logic [ADDR_W-1:0] pc_mem_q [DEPTH];

  logic              pop;
  logic              issue;
  logic              push;
  logic [CNT_W:0]    occupancy;

  assign instValid = resetIn & (count_q != '0) & ~flush;
  assign pop       = instValid & instReady;

  // Entries held plus the word still coming out of the ROM, after this cycle's pop;
  // only issue when that leaves a free slot for the new fetch.
  assign occupancy = {1'b0, count_q} + (CNT_W+1)'(inflight_q) - (CNT_W+1)'(pop);
  assign pcEnable  = resetIn & (flush | (occupancy < DEPTH_C));
  assign issue     = pcEnable & ~flush & resetIn;
  assign push      = inflight_q & ~flush;

  assign instOut = inst_mem_q[rd_ptr_q];
  assign instPc  = pc_mem_q[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    inflight_d = issue;
    tag_pc_d   = pcAddr;
    if (flush) begin
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      inflight_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetIn) begin
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      inflight_q <= 1'b0;
      tag_pc_q   <= '0;
    end else begin
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      inflight_q <= inflight_d;
      tag_pc_q   <= tag_pc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetIn) begin
      for (int i = 0; i < DEPTH; i++) begin
        inst_mem_q[i] <= '0;
        pc_mem_q[i]   <= '0;
      end
    end else if (push) begin
      inst_mem_q[wr_ptr_q] <= romData;
      pc_mem_q[wr_ptr_q]   <= tag_pc_q;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: PC/ROM environment model plus an in-order scoreboard of
// every issued fetch, cleared on flush or reset.
module tb_fetch_queue;

  localparam int ADDR_W = 6;
  localparam int INST_W = 32;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 3;

  logic              clk = 1'b0;
  logic              resetIn = 1'b0;
  logic              flush = 1'b0;
  logic              instReady = 1'b0;
  logic [ADDR_W-1:0] pcAddr;
  logic [INST_W-1:0] romData;
  logic              pcEnable;
  logic              instValid;
  logic [INST_W-1:0] instOut;
  logic [ADDR_W-1:0] instPc;
  logic [CNT_W-1:0]  count;

  logic [ADDR_W-1:0] pc_q = '0;
  logic [ADDR_W-1:0] target = '0;
  logic [INST_W-1:0] rom_q = '0;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } exp_t;
  exp_t exp_q[$];
  logic issued_prev = 1'b0;

  fetch_queue #(.ADDR_W(ADDR_W), .INST_W(INST_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .resetIn(resetIn), .pcAddr(pcAddr), .romData(romData), .flush(flush),
    .pcEnable(pcEnable), .instValid(instValid), .instReady(instReady),
    .instOut(instOut), .instPc(instPc), .count(count)
  );

  assign pcAddr  = pc_q;
  assign romData = rom_q;

  always #5 clk = ~clk;

  // PC stage (step of 2, jump on flush) and synchronous ROM
  always @(posedge clk) begin
    if (!resetIn) pc_q <= '0;
    else if (pcEnable) pc_q <= flush ? target : pc_q + 6'd2;
    rom_q <= 32'hA000_0000 | {26'b0, pc_q};
  end

  function automatic exp_t word_for(input logic [ADDR_W-1:0] a);
    exp_t e;
    e.pc   = a;
    e.inst = 32'hA000_0000 | {26'b0, a};
    return e;
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!resetIn) begin
      checks++;
      if (pcEnable !== 1'b0 || instValid !== 1'b0) begin
        errors++;
        $display("FAIL reset_outputs: pcEnable=%b instValid=%b, required 0/0", pcEnable, instValid);
      end
      exp_q.delete();
      issued_prev = 1'b0;
    end else if (flush) begin
      checks++;
      if (pcEnable !== 1'b1 || instValid !== 1'b0) begin
        errors++;
        $display("FAIL flush_outputs: pcEnable=%b instValid=%b, required 1/0", pcEnable, instValid);
      end
      exp_q.delete();
      issued_prev = 1'b0;
    end else begin
      if (issued_prev) begin
        checks++;
        if (!(int'(count) < DEPTH || (instValid === 1'b1 && instReady))) begin
          errors++;
          $display("FAIL push_full: push with count=%0d and no pop, required room", count);
        end
      end
      if (instValid === 1'b1 && instReady) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: popped pc=%h inst=%h, required no entry", instPc, instOut);
        end else begin
          e = exp_q.pop_front();
          if (instPc !== e.pc || instOut !== e.inst) begin
            errors++;
            $display("FAIL sb_head: got pc=%h inst=%h, required pc=%h inst=%h",
                     instPc, instOut, e.pc, e.inst);
          end
        end
      end
      issued_prev = (pcEnable === 1'b1);
      if (pcEnable === 1'b1) exp_q.push_back(word_for(pcAddr));
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic wait_count3();
    int n = 0;
    instReady = 1'b0;
    while (count != 3'd3 && n < 20) begin
      next_cycle();
      n++;
    end
    checks++;
    if (count !== 3'd3) begin
      errors++;
      $display("FAIL reach_count3: count=%0d, required 3", count);
    end
  endtask

  task automatic test_reset();
    resetIn = 1'b0; flush = 1'b0; instReady = 1'b1;
    repeat (3) next_cycle();
    mid();
    checks++;
    if (count !== 3'd0 || instValid !== 1'b0 || pcEnable !== 1'b0 || instOut !== '0 || instPc !== '0) begin
      errors++;
      $display("FAIL reset_state: count=%0d valid=%b en=%b out=%h pc=%h, required 0/0/0/0/0",
               count, instValid, pcEnable, instOut, instPc);
    end
    next_cycle();
    resetIn = 1'b1;
    mid();
    checks++;
    if (instValid !== 1'b0 || pcEnable !== 1'b1) begin
      errors++;
      $display("FAIL release_c0: valid=%b en=%b, required 0/1", instValid, pcEnable);
    end
    next_cycle(); mid();
    checks++;
    if (instValid !== 1'b0) begin
      errors++;
      $display("FAIL release_c1: valid=%b, required 0", instValid);
    end
    next_cycle(); mid();
    checks++;
    if (instValid !== 1'b1 || instPc !== 6'h00 || instOut !== 32'hA000_0000) begin
      errors++;
      $display("FAIL first_head: valid=%b pc=%h inst=%h, required 1/00/a0000000", instValid, instPc, instOut);
    end
    next_cycle(); mid();
    checks++;
    if (instValid !== 1'b1 || instPc !== 6'h02) begin
      errors++;
      $display("FAIL second_head: valid=%b pc=%h, required 1/02", instValid, instPc);
    end
    repeat (6) next_cycle();
  endtask

  task automatic test_backpressure();
    logic [ADDR_W-1:0] held;
    instReady = 1'b0;
    repeat (10) next_cycle();
    mid();
    checks++;
    if (count !== 3'd4 || pcEnable !== 1'b0) begin
      errors++;
      $display("FAIL stall_full: count=%0d en=%b, required 4/0", count, pcEnable);
    end
    held = pcAddr;
    next_cycle(); mid();
    checks++;
    if (pcAddr !== held) begin
      errors++;
      $display("FAIL pc_frozen: pcAddr=%h, required %h", pcAddr, held);
    end
    instReady = 1'b1;
    repeat (12) next_cycle();
  endtask

  task automatic test_pulse();
    int n = 0;
    instReady = 1'b0;
    while (count != 3'd4 && n < 20) begin
      next_cycle();
      n++;
    end
    checks++;
    if (count !== 3'd4) begin
      errors++;
      $display("FAIL reach_full: count=%0d, required 4", count);
    end
    instReady = 1'b1;
    mid();
    checks++;
    if (pcEnable !== 1'b1) begin
      errors++;
      $display("FAIL pulse_enable: en=%b, required 1", pcEnable);
    end
    next_cycle();
    instReady = 1'b0;
    mid();
    checks++;
    if (count !== 3'd3) begin
      errors++;
      $display("FAIL pulse_count: count=%0d, required 3", count);
    end
    repeat (4) next_cycle();
    mid();
    checks++;
    if (count !== 3'd4) begin
      errors++;
      $display("FAIL refill: count=%0d, required 4", count);
    end
    instReady = 1'b1;
    repeat (8) next_cycle();
  endtask

  task automatic test_flush();
    wait_count3();
    target = 6'h20;
    flush = 1'b1;
    mid();
    next_cycle();
    flush = 1'b0;
    instReady = 1'b1;
    mid();
    checks++;
    if (count !== 3'd0 || instValid !== 1'b0) begin
      errors++;
      $display("FAIL flush_clear: count=%0d valid=%b, required 0/0", count, instValid);
    end
    next_cycle(); mid();
    checks++;
    if (instValid !== 1'b0) begin
      errors++;
      $display("FAIL flush_t2: valid=%b, required 0", instValid);
    end
    next_cycle(); mid();
    checks++;
    if (instValid !== 1'b1 || instPc !== 6'h20 || instOut !== 32'hA000_0020) begin
      errors++;
      $display("FAIL flush_target: valid=%b pc=%h inst=%h, required 1/20/a0000020", instValid, instPc, instOut);
    end
    repeat (6) next_cycle();
  endtask

  task automatic test_reset_mid();
    wait_count3();
    resetIn = 1'b0;
    mid();
    next_cycle();
    resetIn = 1'b1;
    instReady = 1'b1;
    mid();
    checks++;
    if (count !== 3'd0 || instValid !== 1'b0 || instOut !== '0 || instPc !== '0) begin
      errors++;
      $display("FAIL midreset_state: count=%0d valid=%b out=%h pc=%h, required 0/0/0/0",
               count, instValid, instOut, instPc);
    end
    next_cycle(); next_cycle(); mid();
    checks++;
    if (instValid !== 1'b1 || instPc !== 6'h00) begin
      errors++;
      $display("FAIL midreset_restart: valid=%b pc=%h, required 1/00", instValid, instPc);
    end
    repeat (6) next_cycle();
  endtask

  task automatic test_flush_reset();
    wait_count3();
    target = 6'h30;
    flush = 1'b1;
    resetIn = 1'b0;
    mid();
    checks++;
    if (pcEnable !== 1'b0) begin
      errors++;
      $display("FAIL flushreset_en: en=%b, required 0", pcEnable);
    end
    next_cycle();
    flush = 1'b0;
    resetIn = 1'b1;
    instReady = 1'b1;
    mid();
    checks++;
    if (count !== 3'd0 || instValid !== 1'b0) begin
      errors++;
      $display("FAIL flushreset_clear: count=%0d valid=%b, required 0/0", count, instValid);
    end
    next_cycle(); next_cycle(); mid();
    checks++;
    if (instValid !== 1'b1 || instPc !== 6'h00) begin
      errors++;
      $display("FAIL flushreset_restart: valid=%b pc=%h, required 1/00", instValid, instPc);
    end
    repeat (4) next_cycle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running, required to finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_backpressure();
    test_pulse();
    test_flush();
    test_reset_mid();
    test_flush_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
